// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining a byte FIFO: one active-low read strobe per frame,
// then start, 8 data bits LSB first, optional parity and 1-2 stop bits.
module uart_tx_fifo_drain #(
    parameter logic [15:0] CLK_DIV    = 16'd347,
    parameter logic        PARITY_EN  = 1'b0,
    parameter logic        PARITY_ODD = 1'b0,
    parameter logic [1:0]  STOP_BITS  = 2'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] fifo_data_i,
    input  logic       fifo_empty_i,
    output logic       fifo_n_re_o,
    input  logic       tx_en_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
    localparam logic [2:0] S_PARITY = 3'd5;
    localparam logic [2:0] S_STOP   = 3'd6;

    localparam logic [15:0] LAST_CNT  = CLK_DIV - 16'd1;
    localparam logic [2:0]  LAST_STOP = {1'b0, STOP_BITS - 2'd1};

    logic [2:0]  r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [2:0]  r_idx, w_idx_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic        r_par, w_par_nxt;
    logic        r_tx, w_tx_nxt;
    logic        w_bit_end;
    logic        w_timed;

    assign w_bit_end = (r_cnt == LAST_CNT);
    assign w_timed   = (r_state == S_START) || (r_state == S_DATA) ||
                       (r_state == S_PARITY) || (r_state == S_STOP);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        if (w_timed) begin
            w_cnt_nxt = w_bit_end ? 16'd0 : r_cnt + 16'd1;
        end
        case (r_state)
            S_IDLE: begin
                if (tx_en_i && !fifo_empty_i) w_state_nxt = S_FETCH;
            end
            S_FETCH: w_state_nxt = S_LOAD;
            S_LOAD: begin
                w_shift_nxt = fifo_data_i;
                w_par_nxt   = (^fifo_data_i) ^ PARITY_ODD;
                w_cnt_nxt   = 16'd0;
                w_idx_nxt   = 3'd0;
                w_state_nxt = S_START;
            end
            S_START: begin
                if (w_bit_end) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_idx == 3'd7) begin
                        // index is reused to count stop bits
                        w_idx_nxt   = 3'd0;
                        w_state_nxt = PARITY_EN ? S_PARITY : S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_idx == LAST_STOP) begin
                        w_idx_nxt   = 3'd0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Line level follows the next state so tx_o is registered yet aligned with it
    always_comb begin
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[w_idx_nxt];
            S_PARITY: w_tx_nxt = w_par_nxt;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            r_idx   <= 3'd0;
            r_shift <= 8'd0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    assign tx_o        = r_tx;
    assign busy_o      = (r_state != S_IDLE);
    assign fifo_n_re_o = (r_state != S_FETCH);
    assign done_o      = (r_state == S_STOP) && w_bit_end && (r_idx == LAST_STOP);

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: four configurations fed by a FIFO model,
// frames compared cycle-by-cycle against a waveform built from the frame format.
`timescale 1ns/1ps
module tb_uart_tx_fifo_drain;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] fdat [4] = '{8'd0, 8'd0, 8'd0, 8'd0};
  logic [3:0] fe, n_re, tx_en, tx, busy, done;
  logic [7:0] fmem [4][16];
  int wp [4];
  int rp [4] = '{0, 0, 0, 0};
  int scnt [4] = '{0, 0, 0, 0};
  int dcnt [4] = '{0, 0, 0, 0};
  int bad_re [4] = '{0, 0, 0, 0};
  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_fifo_drain #(.CLK_DIV(16'd4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2'd1)) u_a (
    .clk(clk), .rst(rst), .fifo_data_i(fdat[0]), .fifo_empty_i(fe[0]), .fifo_n_re_o(n_re[0]),
    .tx_en_i(tx_en[0]), .tx_o(tx[0]), .busy_o(busy[0]), .done_o(done[0]));
  uart_tx_fifo_drain #(.CLK_DIV(16'd4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2'd1)) u_b (
    .clk(clk), .rst(rst), .fifo_data_i(fdat[1]), .fifo_empty_i(fe[1]), .fifo_n_re_o(n_re[1]),
    .tx_en_i(tx_en[1]), .tx_o(tx[1]), .busy_o(busy[1]), .done_o(done[1]));
  uart_tx_fifo_drain #(.CLK_DIV(16'd4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(2'd1)) u_c (
    .clk(clk), .rst(rst), .fifo_data_i(fdat[2]), .fifo_empty_i(fe[2]), .fifo_n_re_o(n_re[2]),
    .tx_en_i(tx_en[2]), .tx_o(tx[2]), .busy_o(busy[2]), .done_o(done[2]));
  uart_tx_fifo_drain #(.CLK_DIV(16'd2), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2'd2)) u_d (
    .clk(clk), .rst(rst), .fifo_data_i(fdat[3]), .fifo_empty_i(fe[3]), .fifo_n_re_o(n_re[3]),
    .tx_en_i(tx_en[3]), .tx_o(tx[3]), .busy_o(busy[3]), .done_o(done[3]));

  function automatic int div_of(input int k);
    return (k == 3) ? 2 : 4;
  endfunction
  function automatic int pe_of(input int k);
    return (k == 1 || k == 2) ? 1 : 0;
  endfunction
  function automatic int po_of(input int k);
    return (k == 2) ? 1 : 0;
  endfunction
  function automatic int sb_of(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  // FIFO model: registered read data, empty when pointers meet
  always_comb begin
    for (int k = 0; k < 4; k++) fe[k] = (wp[k] == rp[k]);
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (n_re[k] === 1'b0) begin
        fdat[k] <= fmem[k][rp[k][3:0]];
        rp[k]   <= rp[k] + 1;
        scnt[k] <= scnt[k] + 1;
        if (fe[k]) bad_re[k] <= bad_re[k] + 1;
      end
      if (done[k] === 1'b1) dcnt[k] <= dcnt[k] + 1;
    end
  end

  // Frame as a bit list, index 0 = start bit; trailing positions stay at idle level
  function automatic logic [11:0] ref_frame(input int k, input logic [7:0] b);
    logic [11:0] f;
    int ones;
    f = '1;
    f[0] = 1'b0;
    for (int j = 0; j < 8; j++) f[j + 1] = b[j];
    ones = $countones(b);
    if (pe_of(k) == 1) f[9] = (po_of(k) == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
    return f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] b);
    fmem[k][wp[k][3:0]] = b;
    wp[k] = wp[k] + 1;
  endtask

  // Waits for a start bit, then checks every cycle of the frame and the done pulse
  task automatic expect_frame(input int k, input logic [7:0] b, output int gap);
    logic [11:0] fb;
    logic [63:0] ow, ew, dw;
    int d, len;
    fb = ref_frame(k, b);
    d = div_of(k);
    len = (9 + pe_of(k) + sb_of(k)) * d;
    ow = '0; ew = '0; dw = '0; gap = 0;
    @(negedge clk);
    while (tx[k] !== 1'b0 && gap < 300) begin
      gap++;
      @(negedge clk);
    end
    if (gap >= 300) begin
      chk($sformatf("start_timeout_u%0d", k), 64'(tx[k]), 64'd0);
      return;
    end
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge clk);
      ow[i] = tx[k];
      dw[i] = done[k];
      ew[i] = fb[i / d];
    end
    chk($sformatf("frame_u%0d_%02h", k, b), ow, ew);
    chk($sformatf("done_pos_u%0d_%02h", k, b), dw, 64'd1 << (len - 1));
    chk($sformatf("busy_at_done_u%0d", k), 64'(busy[k]), 64'd1);
  endtask

  initial begin
    int g, s0, d0;
    logic [7:0] rb [4];
    rst = 1'b1;
    tx_en = 4'b0000;
    for (int k = 0; k < 4; k++) wp[k] = 0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_tx_u%0d", k), 64'(tx[k]), 64'd1);
      chk($sformatf("rst_busy_u%0d", k), 64'(busy[k]), 64'd0);
      chk($sformatf("rst_done_u%0d", k), 64'(done[k]), 64'd0);
      chk($sformatf("rst_nre_u%0d", k), 64'(n_re[k]), 64'd1);
    end
    rst = 1'b0;
    @(negedge clk);

    // single frame 0xA5, no parity
    s0 = scnt[0];
    push(0, 8'hA5);
    tx_en[0] = 1'b1;
    expect_frame(0, 8'hA5, g);
    tx_en[0] = 1'b0;
    @(negedge clk);
    chk("t1_busy_after", 64'(busy[0]), 64'd0);
    chk("t1_tx_after", 64'(tx[0]), 64'd1);
    chk("t1_strobes", 64'(scnt[0] - s0), 64'd1);

    // three back-to-back frames
    s0 = scnt[0];
    push(0, 8'h55); push(0, 8'h0F); push(0, 8'hFF);
    tx_en[0] = 1'b1;
    expect_frame(0, 8'h55, g);
    expect_frame(0, 8'h0F, g);
    chk("t3_gap1", 64'(g), 64'd3);
    expect_frame(0, 8'hFF, g);
    chk("t3_gap2", 64'(g), 64'd3);
    @(negedge clk);
    chk("t3_busy_after", 64'(busy[0]), 64'd0);
    repeat (20) @(negedge clk);
    chk("t3_idle_busy", 64'(busy[0]), 64'd0);
    chk("t3_idle_tx", 64'(tx[0]), 64'd1);
    chk("t3_fifo_empty", 64'(fe[0]), 64'd1);
    chk("t3_strobes", 64'(scnt[0] - s0), 64'd3);
    tx_en[0] = 1'b0;

    // parity variants
    push(1, 8'hA5); push(1, 8'h07);
    tx_en[1] = 1'b1;
    expect_frame(1, 8'hA5, g);
    expect_frame(1, 8'h07, g);
    tx_en[1] = 1'b0;
    push(2, 8'hA5);
    tx_en[2] = 1'b1;
    expect_frame(2, 8'hA5, g);
    tx_en[2] = 1'b0;

    // two stop bits, CLK_DIV=2
    push(3, 8'h00);
    tx_en[3] = 1'b1;
    expect_frame(3, 8'h00, g);
    tx_en[3] = 1'b0;

    // random bursts on every configuration
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        rb[i] = 8'($urandom);
        push(k, rb[i]);
      end
      tx_en[k] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        expect_frame(k, rb[i], g);
        if (i > 0) chk($sformatf("rnd_gap_u%0d", k), 64'(g), 64'd3);
      end
      tx_en[k] = 1'b0;
      repeat (4) @(negedge clk);
      chk($sformatf("rnd_empty_u%0d", k), 64'(fe[k]), 64'd1);
    end

    // enable low holds the engine idle; dropping it mid-frame stops after that frame
    s0 = scnt[0];
    push(0, 8'h3C); push(0, 8'hC3);
    g = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx[0] === 1'b1 && busy[0] === 1'b0) g++;
    end
    chk("t4_idle_high", 64'(g), 64'd100);
    chk("t4_no_strobe", 64'(scnt[0] - s0), 64'd0);
    tx_en[0] = 1'b1;
    fork
      begin
        repeat (14) @(negedge clk);
        tx_en[0] = 1'b0;
      end
    join_none
    expect_frame(0, 8'h3C, g);
    repeat (40) @(negedge clk);
    chk("t4_one_strobe", 64'(scnt[0] - s0), 64'd1);
    chk("t4_fifo_left", 64'(wp[0] - rp[0]), 64'd1);
    chk("t4_busy_idle", 64'(busy[0]), 64'd0);
    chk("t4_tx_idle", 64'(tx[0]), 64'd1);

    // reset during data bit 3 aborts the frame
    s0 = scnt[0];
    d0 = dcnt[0];
    push(0, 8'h96);
    tx_en[0] = 1'b1;
    g = 0;
    @(negedge clk);
    while (tx[0] !== 1'b0 && g < 50) begin
      g++;
      @(negedge clk);
    end
    chk("t5_start", 64'(tx[0]), 64'd0);
    repeat (17) @(negedge clk);
    rst = 1'b1;
    tx_en[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_tx_high", 64'(tx[0]), 64'd1);
    chk("t5_busy_low", 64'(busy[0]), 64'd0);
    chk("t5_done_low", 64'(done[0]), 64'd0);
    repeat (40) @(negedge clk);
    chk("t5_no_done", 64'(dcnt[0] - d0), 64'd0);
    chk("t5_one_strobe", 64'(scnt[0] - s0), 64'd1);
    chk("t5_fifo_left", 64'(wp[0] - rp[0]), 64'd1);
    chk("t5_busy_idle", 64'(busy[0]), 64'd0);

    for (int k = 0; k < 4; k++) chk($sformatf("strobe_when_empty_u%0d", k), 64'(bad_re[k]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
- UART transmit engine that sits on the read side of the byte FIFO: pops one byte at a time through the FIFO's active-low read strobe and serialises it onto the TX line.
- Each frame: start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
- Bit timing comes from an internal clock-divider counter; the engine drains the FIFO back-to-back while it is non-empty and transmit is enabled.

Parameters:
- CLK_DIV, 16'd347, clocks per bit (40 MHz / 115200); legal range 2..65535.
- PARITY_EN, 1'b0, 1 = insert parity bit after data.
- PARITY_ODD, 1'b0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 2'd1, number of stop bits; legal values 1 or 2.

Ports:
- clk, input, 1, system clock, ≥40 MHz.
- rst, input, 1, reset; synchronous, active-high.
- fifo_data_i, input, 8, FIFO registered read data; valid the cycle after a read strobe.
- fifo_empty_i, input, 1, FIFO empty flag, active-high.
- fifo_n_re_o, output, 1, FIFO read strobe, active-low; one cycle per byte.
- tx_en_i, input, 1, transmit enable; sampled only in IDLE.
- tx_o, output, 1, serial line; idle high.
- busy_o, output, 1, high whenever state ≠ IDLE.
- done_o, output, 1, one-cycle pulse on the last clock of the final stop bit.

Behaviour:
- Reset (rst=1 at posedge), effective the following cycle:
  - state=IDLE, tx_o=1, fifo_n_re_o=1, busy_o=0, done_o=0.
  - Baud counter, bit index and shift register cleared.
  - Reset mid-frame aborts the frame; tx_o returns high immediately and no further read strobe is issued.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE:
  - If tx_en_i=1 and fifo_empty_i=0, go to FETCH; otherwise stay.
  - tx_o=1.
- FETCH:
  - Exactly one cycle; fifo_n_re_o=0 decoded from the state register, so it is glitch-free.
  - Next state LOAD.
- LOAD:
  - One cycle; capture fifo_data_i into the shift register.
  - Compute parity: XOR of the 8 bits, inverted when PARITY_ODD=1.
  - Clear the baud counter; go to START.
- START: tx_o=0 for CLK_DIV cycles, then DATA with bit index 0.
- DATA:
  - tx_o = shift register bit [index] for CLK_DIV cycles per bit, LSB first.
  - After bit 7, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: tx_o = parity bit for CLK_DIV cycles, then STOP.
- STOP:
  - tx_o=1 for STOP_BITS×CLK_DIV cycles.
  - done_o=1 on the last of those cycles; then IDLE.
- Baud counter:
  - 16-bit, counts 0..CLK_DIV-1; wraps to 0 at each bit boundary.
  - Bit advance occurs when count = CLK_DIV-1.
- tx_o is registered. First start-bit cycle is 3 clocks after IDLE sees the go condition (IDLE→FETCH→LOAD→START).
- Back-to-back frames:
  - Gap after the stop bit(s) is exactly 3 clocks of tx_o=1 (IDLE, FETCH, LOAD) before the next start bit.
  - The next FETCH is issued only if tx_en_i=1 and fifo_empty_i=0 in that IDLE cycle.
- Simultaneous events:
  - tx_en_i falling mid-frame has no effect; the current frame completes and the engine stops in IDLE.
  - FIFO writes during a frame are irrelevant until the next IDLE sample.
- Empty handling: a read strobe is never issued when fifo_empty_i=1. The engine is the FIFO's sole reader, so the FIFO cannot go empty between IDLE and FETCH.
- No data loss: exactly one read strobe per transmitted frame; frame count equals strobe count.

Test Plan:
1. CLK_DIV=4, PARITY_EN=0, STOP_BITS=1; reset; push 0xA5; tx_en_i=1.
   - Exactly one fifo_n_re_o low pulse.
   - tx_o sequence in 4-cycle bits: 0,1,0,1,0,0,1,0,1,1 (40 cycles).
   - done_o pulses once; busy_o falls the next cycle.
2. PARITY_EN=1, PARITY_ODD=0, byte 0xA5 → parity bit 0, frame 44 cycles. Repeat with PARITY_ODD=1 → parity bit 1. Byte 0x07, even → parity bit 1.
3. Push 0x55, 0x0F, 0xFF with tx_en_i=1 continuously:
   - Three frames, three read strobes.
   - Exactly 3 high cycles between each stop end and the next start.
   - FIFO empty afterwards; engine remains IDLE with tx_o=1.
4. tx_en_i=0 with FIFO holding 2 bytes → no strobe, tx_o=1 for 100 cycles.
   - Raise tx_en_i, drop it during the first frame's DATA state.
   - First frame completes; second byte is not fetched.
5. Assert rst for 1 cycle during DATA bit 3 → next cycle tx_o=1, busy_o=0, done_o never pulses, no extra read strobe; FIFO still holds any remaining bytes.
6. STOP_BITS=2, CLK_DIV=2, byte 0x00 → tx_o low for 18 cycles, then high for 4, done_o on the 4th high cycle.
